// File: rtl/fetch_pkg.sv
// Shared constants, PC_Select encodings and fetch FSM state type for the
// instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] INC_STEP        = 32'd4;

    localparam logic [1:0] PCSEL_RA   = 2'b00;
    localparam logic [1:0] PCSEL_INC  = 2'b01;
    localparam logic [1:0] PCSEL_INT  = 2'b10;
    localparam logic [1:0] PCSEL_TEMP = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC target: incrementer (+4 or +offset) followed by the
// PC_Select mux, plus a word-alignment flag for the chosen target.
module pc_target_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0100
) (
    input  logic [31:0] pc,
    input  logic [31:0] pc_temp,
    input  logic [31:0] ra_in,
    input  logic [31:0] branch_offset,
    input  logic [1:0]  pc_select,
    input  logic        inc_select,
    output logic [31:0] target,
    output logic        aligned
);

    logic [31:0] inc_value;

    // Wraps modulo 2^32 with no overflow indication.
    assign inc_value = pc + (inc_select ? branch_offset : INC_STEP);

    always_comb begin
        target = ra_in;
        unique case (pc_select)
            PCSEL_RA:   target = ra_in;
            PCSEL_INC:  target = inc_value;
            PCSEL_INT:  target = INT_VECTOR;
            PCSEL_TEMP: target = pc_temp;
            default:    target = ra_in;
        endcase
    end

    assign aligned = is_word_aligned(target);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, return-address register and instruction register with a
// wait-state fetch handshake toward instruction memory.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0100,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PC_Enable,
    input  logic        PC_Enable_Write_Back_Stage_Jump_Branch,
    input  logic [1:0]  PC_Select,
    input  logic        INC_Select,
    input  logic        IR_Enable,
    input  logic [31:0] RA_In,
    input  logic [31:0] Branch_Offset,
    input  logic [31:0] Mem_Instruction,
    input  logic        Mem_Ready,
    output logic [31:0] Fetch_Address,
    output logic        Fetch_Request,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] PC_Temp,
    output logic        Fetch_Stall,
    output logic        Fetch_Timeout,
    output logic        Misaligned_Fault
);

    // state   | meaning
    // IDLE    | no fetch outstanding; a ready fetch completes in-cycle
    // WAIT    | memory slow; address held, stage counter stalled

    localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

    fetch_state_t state, state_next;
    logic [7:0]   wait_cnt;
    logic [31:0]  addr_hold;
    logic [31:0]  target;
    logic         target_aligned;

    logic capture;
    logic capture_nop;
    logic start_wait;
    logic cnt_inc;
    logic pc_update_req;

    pc_target_gen #(
        .INT_VECTOR(INT_VECTOR)
    ) u_target (
        .pc           (PC),
        .pc_temp      (PC_Temp),
        .ra_in        (RA_In),
        .branch_offset(Branch_Offset),
        .pc_select    (PC_Select),
        .inc_select   (INC_Select),
        .target       (target),
        .aligned      (target_aligned)
    );

    // Both enables select the same target through one mux, so the write-back
    // enable taking priority collapses to a single update.
    assign pc_update_req = (state == ST_IDLE) &&
                           (PC_Enable || PC_Enable_Write_Back_Stage_Jump_Branch);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        Fetch_Address = PC;
        Fetch_Request = IR_Enable;
        Fetch_Stall   = 1'b0;
        capture       = 1'b0;
        capture_nop   = 1'b0;
        start_wait    = 1'b0;
        cnt_inc       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (IR_Enable) begin
                    if (Mem_Ready) begin
                        capture = 1'b1;
                    end else begin
                        start_wait = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                Fetch_Address = addr_hold;
                Fetch_Request = 1'b1;
                Fetch_Stall   = 1'b1;
                if (Mem_Ready) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_cnt == MAX_WAIT_CNT) begin
                    capture_nop = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PC               <= RESET_VECTOR;
            PC_Temp          <= RESET_VECTOR + INC_STEP;
            Instruction      <= NOP_INSTRUCTION;
            addr_hold        <= '0;
            wait_cnt         <= '0;
            Fetch_Timeout    <= 1'b0;
            Misaligned_Fault <= 1'b0;
        end else begin
            if (pc_update_req) begin
                if (target_aligned) begin
                    PC      <= target;
                    PC_Temp <= PC + INC_STEP;
                end else begin
                    Misaligned_Fault <= 1'b1;
                end
            end

            // The pending fetch keeps the pre-update PC even if PC moves now.
            if (start_wait) begin
                addr_hold <= Fetch_Address;
                wait_cnt  <= 8'd1;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else if (state_next == ST_IDLE) begin
                wait_cnt <= '0;
            end

            if (capture) begin
                Instruction <= Mem_Instruction;
            end else if (capture_nop) begin
                Instruction   <= NOP_INSTRUCTION;
                Fetch_Timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] INT_VEC = 32'h0000_0100;
    localparam int          MAXW    = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        PC_Enable = 1'b0;
    logic        PC_Enable_Write_Back_Stage_Jump_Branch = 1'b0;
    logic [1:0]  PC_Select = 2'b00;
    logic        INC_Select = 1'b0;
    logic        IR_Enable = 1'b0;
    logic [31:0] RA_In = '0;
    logic [31:0] Branch_Offset = '0;
    logic [31:0] Mem_Instruction = '0;
    logic        Mem_Ready = 1'b0;
    logic [31:0] Fetch_Address;
    logic        Fetch_Request;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] PC_Temp;
    logic        Fetch_Stall;
    logic        Fetch_Timeout;
    logic        Misaligned_Fault;

    int n_vec = 0;
    int n_bad = 0;

    instruction_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .INT_VECTOR  (INT_VEC),
        .MAX_WAIT    (MAXW)
    ) dut (
        .Clock                                 (Clock),
        .Reset                                 (Reset),
        .PC_Enable                             (PC_Enable),
        .PC_Enable_Write_Back_Stage_Jump_Branch(PC_Enable_Write_Back_Stage_Jump_Branch),
        .PC_Select                             (PC_Select),
        .INC_Select                            (INC_Select),
        .IR_Enable                             (IR_Enable),
        .RA_In                                 (RA_In),
        .Branch_Offset                         (Branch_Offset),
        .Mem_Instruction                       (Mem_Instruction),
        .Mem_Ready                             (Mem_Ready),
        .Fetch_Address                         (Fetch_Address),
        .Fetch_Request                         (Fetch_Request),
        .Instruction                           (Instruction),
        .PC                                    (PC),
        .PC_Temp                               (PC_Temp),
        .Fetch_Stall                           (Fetch_Stall),
        .Fetch_Timeout                         (Fetch_Timeout),
        .Misaligned_Fault                      (Misaligned_Fault)
    );

    always #5 Clock = ~Clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic pe, input logic wb, input logic [1:0] sel,
                         input logic inc, input logic ir, input logic [31:0] ra,
                         input logic [31:0] off, input logic [31:0] data, input logic rdy);
        PC_Enable = pe;
        PC_Enable_Write_Back_Stage_Jump_Branch = wb;
        PC_Select = sel;
        INC_Select = inc;
        IR_Enable = ir;
        RA_In = ra;
        Branch_Offset = off;
        Mem_Instruction = data;
        Mem_Ready = rdy;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 2'b00, 0, 0, '0, '0, '0, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        #7;
        Reset = 1'b0;
        tick();
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_temp, m_ir, m_addr;
    logic        m_busy, m_tout, m_fault;
    int          m_waited;

    task automatic model_reset();
        m_pc = 32'h0; m_temp = 32'h4; m_ir = 32'h0; m_addr = '0;
        m_busy = 0; m_tout = 0; m_fault = 0; m_waited = 0;
    endtask

    task automatic model_step();
        logic [31:0] old_pc, tgt, step;
        old_pc = m_pc;
        if (!m_busy) begin
            if (PC_Enable || PC_Enable_Write_Back_Stage_Jump_Branch) begin
                step = INC_Select ? Branch_Offset : 32'd4;
                case (PC_Select)
                    2'd0: tgt = RA_In;
                    2'd1: tgt = old_pc + step;
                    2'd2: tgt = INT_VEC;
                    default: tgt = m_temp;
                endcase
                if (tgt % 4 == 0) begin
                    m_pc = tgt;
                    m_temp = old_pc + 4;
                end else begin
                    m_fault = 1;
                end
            end
            if (IR_Enable) begin
                if (Mem_Ready) m_ir = Mem_Instruction;
                else begin
                    m_busy = 1; m_addr = old_pc; m_waited = 1;
                end
            end
        end else if (Mem_Ready) begin
            m_ir = Mem_Instruction; m_busy = 0;
        end else if (m_waited >= MAXW) begin
            m_ir = 32'h0; m_tout = 1; m_busy = 0;
        end else begin
            m_waited++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        pe, wb;
        logic [1:0]  sel;
        logic        inc, ir, rdy;
        logic [31:0] ra, off, data;
        logic [31:0] exp_addr, exp_pc, exp_temp, exp_ir;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic pe, input logic wb, input logic [1:0] sel,
                                input logic inc, input logic ir, input logic rdy,
                                input logic [31:0] ra, input logic [31:0] off,
                                input logic [31:0] data, input logic [31:0] ea,
                                input logic [31:0] ep, input logic [31:0] et,
                                input logic [31:0] ei, input logic ef);
        vec_t v;
        v.pe = pe; v.wb = wb; v.sel = sel; v.inc = inc; v.ir = ir; v.rdy = rdy;
        v.ra = ra; v.off = off; v.data = data;
        v.exp_addr = ea; v.exp_pc = ep; v.exp_temp = et; v.exp_ir = ei; v.exp_fault = ef;
        return v;
    endfunction

    initial begin
        //             pe wb sel  inc ir rdy ra      off    data          addr   pc     temp   ir            flt
        vecs[0] = mk(1, 0, 2'd1, 0, 1, 1, 32'h0,   32'h0,  32'h1111_1111, 32'h0,   32'h4,   32'h4,  32'h1111_1111, 0);
        vecs[1] = mk(1, 0, 2'd1, 1, 0, 0, 32'h0,   32'h20, 32'h0,         32'h4,   32'h24,  32'h8,  32'h1111_1111, 0);
        vecs[2] = mk(0, 1, 2'd0, 0, 0, 0, 32'h80,  32'h0,  32'h0,         32'h24,  32'h80,  32'h28, 32'h1111_1111, 0);
        vecs[3] = mk(1, 0, 2'd3, 0, 0, 0, 32'h0,   32'h0,  32'h0,         32'h80,  32'h28,  32'h84, 32'h1111_1111, 0);
        vecs[4] = mk(1, 0, 2'd2, 0, 0, 0, 32'h0,   32'h0,  32'h0,         32'h28,  32'h100, 32'h2C, 32'h1111_1111, 0);
        vecs[5] = mk(0, 0, 2'd0, 0, 1, 1, 32'h0,   32'h0,  32'hCAFE_F00D, 32'h100, 32'h100, 32'h2C, 32'hCAFE_F00D, 0);
        vecs[6] = mk(0, 0, 2'd0, 0, 0, 1, 32'h0,   32'h0,  32'h5,         32'h100, 32'h100, 32'h2C, 32'hCAFE_F00D, 0);
        vecs[7] = mk(1, 0, 2'd0, 0, 0, 0, 32'h102, 32'h0,  32'h0,         32'h100, 32'h100, 32'h2C, 32'hCAFE_F00D, 1);

        // reset state
        Reset = 1'b1;
        #2;
        check("reset_pc", PC, 32'h0);
        check("reset_temp", PC_Temp, 32'h4);
        check("reset_ir", Instruction, 32'h0);
        check("reset_flags", {Fetch_Stall, Fetch_Timeout, Misaligned_Fault}, 3'b000);
        #5;
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pe, vecs[i].wb, vecs[i].sel, vecs[i].inc, vecs[i].ir,
                  vecs[i].ra, vecs[i].off, vecs[i].data, vecs[i].rdy);
            #1;
            check($sformatf("tbl%0d_addr", i), Fetch_Address, vecs[i].exp_addr);
            check($sformatf("tbl%0d_req", i), Fetch_Request, vecs[i].ir);
            tick();
            check($sformatf("tbl%0d_pc", i), PC, vecs[i].exp_pc);
            check($sformatf("tbl%0d_temp", i), PC_Temp, vecs[i].exp_temp);
            check($sformatf("tbl%0d_ir", i), Instruction, vecs[i].exp_ir);
            check($sformatf("tbl%0d_fault", i), Misaligned_Fault, vecs[i].exp_fault);
        end

        // zero-latency fetch with PC increment
        do_reset();
        drive(1, 0, 2'd0, 0, 0, 32'h10, 0, 0, 0); tick();
        drive(1, 0, 2'd1, 0, 1, 0, 0, 32'hDEAD_BEEF, 1);
        #1 check("fast_stall", Fetch_Stall, 1'b0);
        tick();
        check("fast_ir", Instruction, 32'hDEAD_BEEF);
        check("fast_pc", PC, 32'h14);
        check("fast_temp", PC_Temp, 32'h14);
        check("fast_stall_after", Fetch_Stall, 1'b0);

        // slow memory: ready on the third WAIT cycle; enables ignored in WAIT
        drive(1, 0, 2'd0, 0, 0, 32'h20, 0, 0, 0); tick();
        drive(1, 0, 2'd1, 0, 1, 0, 0, 32'h0, 0);
        #1 check("slow_addr0", Fetch_Address, 32'h20);
        tick();
        check("slow_pc", PC, 32'h24);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'd2, 0, 1, 0, 0, 32'hA5A5_5A5A, (i == 2));
            #1;
            check($sformatf("slow_stall%0d", i), Fetch_Stall, 1'b1);
            check($sformatf("slow_addr%0d", i + 1), Fetch_Address, 32'h20);
            check($sformatf("slow_req%0d", i), Fetch_Request, 1'b1);
            tick();
        end
        idle_inputs();
        check("slow_ir", Instruction, 32'hA5A5_5A5A);
        check("slow_stall_end", Fetch_Stall, 1'b0);
        check("slow_pc_held", PC, 32'h24);

        // timeout after MAX_WAIT cycles in WAIT
        drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0); tick();
        idle_inputs();
        for (int i = 0; i < MAXW; i++) begin
            check($sformatf("tout_stall%0d", i), Fetch_Stall, 1'b1);
            check($sformatf("tout_flag%0d", i), Fetch_Timeout, 1'b0);
            tick();
        end
        check("tout_stall_end", Fetch_Stall, 1'b0);
        check("tout_ir_nop", Instruction, 32'h0);
        check("tout_flag", Fetch_Timeout, 1'b1);
        tick(); tick();
        check("tout_sticky", Fetch_Timeout, 1'b1);

        // async reset mid-WAIT, then fetch from address 0
        do_reset();
        drive(1, 0, 2'd0, 0, 1, 32'h30, 0, 32'h77, 1); tick();
        drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0); tick();
        idle_inputs();
        check("rst_wait_entered", Fetch_Stall, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("rst_async_pc", PC, 32'h0);
        check("rst_async_ir", Instruction, 32'h0);
        check("rst_async_stall", Fetch_Stall, 1'b0);
        Reset = 1'b0;
        tick();
        drive(0, 0, 2'd0, 0, 1, 0, 0, 32'h99, 1);
        #1 check("rst_refetch_addr", Fetch_Address, 32'h0);
        tick();
        check("rst_refetch_ir", Instruction, 32'h99);

        // wrap-around branch and misaligned rejection
        do_reset();
        drive(1, 0, 2'd0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0); tick();
        drive(0, 1, 2'd1, 1, 0, 0, 32'h8, 0, 0); tick();
        check("wrap_pc", PC, 32'h4);
        check("wrap_fault", Misaligned_Fault, 1'b0);
        drive(1, 0, 2'd0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0); tick();
        drive(0, 1, 2'd1, 1, 0, 0, 32'h6, 0, 0); tick();
        check("mis_pc_hold", PC, 32'hFFFF_FFFC);
        check("mis_temp_hold", PC_Temp, 32'h8);
        check("mis_fault", Misaligned_Fault, 1'b1);
        idle_inputs(); tick();
        check("mis_sticky", Misaligned_Fault, 1'b1);

        // both enables in one cycle: one update to RA_In
        do_reset();
        drive(1, 1, 2'd0, 0, 0, 32'h40, 0, 0, 0); tick();
        check("both_pc", PC, 32'h40);
        check("both_temp", PC_Temp, 32'h4);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, off;
            ra  = $urandom() & 32'hFFFF_FFFC;
            off = $urandom_range(0, 64) * 4 - 128;
            if ($urandom_range(0, 19) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) off[1:0] = 2'($urandom_range(1, 3));
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) == 0, ra, off, $urandom(),
                  $urandom_range(0, 3) == 0);
            #1;
            check("rnd_addr", Fetch_Address, m_busy ? m_addr : m_pc);
            check("rnd_req", Fetch_Request, m_busy | IR_Enable);
            check("rnd_stall", Fetch_Stall, m_busy);
            tick();
            model_step();
            check("rnd_pc", PC, m_pc);
            check("rnd_temp", PC_Temp, m_temp);
            check("rnd_ir", Instruction, m_ir);
            check("rnd_flags", {Fetch_Timeout, Misaligned_Fault}, {m_tout, m_fault});
            if (m_fault && $urandom_range(0, 9) == 0) begin
                do_reset();
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side neighbour of the control signal generator. Consumes its PC_Enable, PC_Enable_Write_Back_Stage_Jump_Branch, PC_Select, INC_Select and IR_Enable, and produces the Instruction word it decodes.
- Holds PC, return-address register PC_Temp and the instruction register.
- Runs a wait-state fetch handshake with instruction memory. Raises Fetch_Stall so the stage counter holds while memory is slow.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- INT_VECTOR, 32'h0000_0100, target for PC_Select=2'b10
- MAX_WAIT, 8, wait cycles before a fetch times out (1..255)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- PC_Enable  in  1  fetch-stage PC update
- PC_Enable_Write_Back_Stage_Jump_Branch  in  1  write-back-stage jump/branch PC update
- PC_Select  in  2  00 RA_In, 01 incrementer, 10 INT_VECTOR, 11 PC_Temp
- INC_Select  in  1  0: +4, 1: +Branch_Offset
- IR_Enable  in  1  start fetch / capture instruction
- RA_In  in  32  register jump target
- Branch_Offset  in  32  sign-extended byte offset (Instruction_Immediate)
- Mem_Instruction  in  32  instruction memory read data
- Mem_Ready  in  1  memory data valid this cycle
- Fetch_Address  out  32  address presented to instruction memory
- Fetch_Request  out  1  memory read strobe
- Instruction  out  32  instruction register
- PC  out  32  program counter
- PC_Temp  out  32  return address
- Fetch_Stall  out  1  hold stage counter
- Fetch_Timeout  out  1  sticky: a fetch timed out
- Misaligned_Fault  out  1  sticky: rejected non-word-aligned target

Behaviour:

Reset (async, any state):
- PC=RESET_VECTOR, PC_Temp=RESET_VECTOR+4, Instruction=NOP_INSTRUCTION.
- FSM=IDLE, wait counter=0, all flags and strobes 0.

Target computation (combinational):
- inc = PC + (INC_Select ? Branch_Offset : 32'd4), modulo 2^32, wrap silent.
- target = mux(PC_Select) per port list.

PC update:
- On PC_Enable or PC_Enable_Write_Back_Stage_Jump_Branch with target[1:0]==0: PC<=target, PC_Temp<=PC+4.
- If both enables are high, the write-back enable has priority (single update).
- target[1:0]!=0: PC and PC_Temp hold; Misaligned_Fault<=1, sticky until Reset.

FSM states IDLE, WAIT:
- IDLE: Fetch_Address=PC (combinational), Fetch_Request=IR_Enable.
- IDLE, IR_Enable & Mem_Ready: Instruction<=Mem_Instruction; stay IDLE. Zero extra latency.
- IDLE, IR_Enable & !Mem_Ready: latch Fetch_Address into addr_hold, counter<=1, go WAIT.
- Any PC update requested in that same cycle still occurs; the pending fetch keeps using the old PC via addr_hold.
- WAIT: Fetch_Address=addr_hold, Fetch_Request=1, Fetch_Stall=1 (combinational from state).
- WAIT: IR_Enable, PC_Enable and PC_Enable_Write_Back_Stage_Jump_Branch are ignored.
- WAIT, Mem_Ready: Instruction<=Mem_Instruction, go IDLE. Fetch_Stall drops the following cycle.
- WAIT, !Mem_Ready & counter==MAX_WAIT: Instruction<=NOP_INSTRUCTION, Fetch_Timeout<=1 (sticky), go IDLE.
- WAIT, otherwise: counter++.
- Mem_Ready outside a request is ignored.
- IR_Enable low: Instruction holds.
- Reset in WAIT aborts the fetch with no capture.

Decomposition:
- Shared package fetch_pkg: NOP_INSTRUCTION (32'h0000_0000), PC_Select encodings (PCSEL_RA, PCSEL_INC, PCSEL_INT, PCSEL_TEMP), INC_STEP=4, fetch FSM state enum.
- One natural sub-module: pc_target_gen, the combinational incrementer/mux producing target and the aligned flag.

Test Plan:
- Reset mid-WAIT -> PC=0, Instruction=0, Fetch_Stall=0 immediately (async); next IR_Enable fetches address 0.
- PC=0x10, IR_Enable+PC_Enable, Select=01, INC=0, Mem_Ready=1, data 0xDEADBEEF -> Instruction=0xDEADBEEF, PC=0x14, PC_Temp=0x14, no stall.
- PC=0x20, IR_Enable+PC_Enable, Mem_Ready delayed 3 cycles -> Fetch_Stall high 3 cycles, Fetch_Address=0x20 throughout, PC=0x24, instruction captured on ready.
- Mem_Ready never asserted, MAX_WAIT=8 -> after 8 WAIT cycles Instruction=NOP, Fetch_Timeout=1 and stays 1.
- Write-back branch, PC=0xFFFF_FFFC, INC=1, offset=8 -> PC=0x0000_0004 (wrap); separately offset=6 -> PC holds, Misaligned_Fault=1.
- Both enables same cycle: fetch Select=01 INC=0, write-back Select=00 with RA_In=0x40 -> PC=0x40 (write-back wins).
